risc_cpu: RTL and testbench

//  8-bit accumulator CPU ("VeriRisc" class) with an internal 32x8 unified program/data memory.
//  - Executes the preloaded program from address 0 after reset and raises HALT on an HLT instruction.
//  - Top-level block of the CPU subsystem; the bench preloads memory hierarchically.
//  - Required hierarchical names: memory array `mem` (reg [7:0] mem[0:31]) and program counter `pc` (5 bits),

---
 rtl/risc_cpu_pkg.sv | 32 +++
 rtl/risc_cpu_ctrl.sv | 78 +++++++
 rtl/risc_cpu.sv | 93 +++++++++
 tb/tb_risc_cpu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/risc_cpu_pkg.sv
// Shared constants for the 8-bit accumulator CPU: widths, opcodes and phases.
// Optional trace output is enabled by defining CPU_TRACE_EN.
package risc_cpu_pkg;

   localparam int DWIDTH    = 8;
   localparam int AWIDTH    = 5;
   localparam int MEM_WORDS = 32;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   localparam logic [2:0] PH_INST_ADDR  = 3'd0;
   localparam logic [2:0] PH_INST_FETCH = 3'd1;
   localparam logic [2:0] PH_INST_LOAD  = 3'd2;
   localparam logic [2:0] PH_IDLE       = 3'd3;
   localparam logic [2:0] PH_OP_ADDR    = 3'd4;
   localparam logic [2:0] PH_OP_FETCH   = 3'd5;
   localparam logic [2:0] PH_ALU_OP     = 3'd6;
   localparam logic [2:0] PH_STORE      = 3'd7;

   // Opcodes whose result is written back into the accumulator.
   function automatic logic is_aluop(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage

// File: rtl/risc_cpu_ctrl.sv
// Phase sequencer and instruction decode. The phase counter and the halt flag
// live here; every datapath strobe is suppressed once halted so the CPU freezes.
module risc_cpu_ctrl
   import risc_cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic [2:0] phase,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       wr,
   output logic       halt
);

   logic aluop;

   assign aluop = is_aluop(opcode);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= PH_INST_ADDR;
         halt  <= 1'b0;
      end else if (!halt) begin
         phase <= phase + 3'd1;
         if (phase == PH_OP_ADDR && opcode == OP_HLT)
            halt <= 1'b1;
      end
   end

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      if (!halt) begin
         case (phase)
            PH_INST_ADDR: begin
               sel = 1'b1;
            end
            PH_INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
               inc_pc = 1'b1;
            end
            PH_OP_FETCH: begin
               rd = aluop;
            end
            PH_ALU_OP: begin
               rd     = aluop;
               inc_pc = (opcode == OP_SKZ) && zero;
               ld_pc  = (opcode == OP_JMP);
            end
            default: begin
               ld_ac = aluop;
               ld_pc = (opcode == OP_JMP);
               wr    = (opcode == OP_STO);
            end
         endcase
      end
   end

endmodule

// File: rtl/risc_cpu.sv
// VeriRisc-class accumulator CPU with a 32x8 unified memory; runs from address 0
// after reset and raises HALT on HLT. Define CPU_TRACE_EN for a per-instruction trace.
module risc_cpu
   import risc_cpu_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   output logic HALT
);

   reg   [DWIDTH-1:0] mem [0:MEM_WORDS-1];
   logic [AWIDTH-1:0] pc;
   logic [DWIDTH-1:0] ir;
   logic [DWIDTH-1:0] ac;

   logic [2:0]        phase;
   logic [2:0]        opcode;
   logic [AWIDTH-1:0] addr;
   logic [DWIDTH-1:0] mem_rdata;
   logic [DWIDTH-1:0] alu_out;
   logic              zero;
   logic              sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, halt;

   assign opcode    = ir[7:5];
   assign zero      = (ac == '0);
   assign addr      = sel ? pc : ir[AWIDTH-1:0];
   assign mem_rdata = mem[addr];
   assign HALT      = halt;

   risc_cpu_ctrl u_ctrl (
      .clk    (CLK),
      .rst_n  (RST),
      .opcode (opcode),
      .zero   (zero),
      .phase  (phase),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .ld_ac  (ld_ac),
      .wr     (wr),
      .halt   (halt)
   );

   always_comb begin
      case (opcode)
         OP_ADD:  alu_out = ac + mem_rdata;
         OP_AND:  alu_out = ac & mem_rdata;
         OP_XOR:  alu_out = ac ^ mem_rdata;
         default: alu_out = mem_rdata;
      endcase
   end

   // Jump target wins over increment when both are requested in the same phase.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         pc <= '0;
      else if (ld_pc)
         pc <= ir[AWIDTH-1:0];
      else if (inc_pc)
         pc <= pc + 5'd1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         ir <= '0;
      else if (ld_ir && rd)
         ir <= mem_rdata;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         ac <= '0;
      else if (ld_ac)
         ac <= alu_out;
   end

   // Memory contents survive reset so a preloaded program can be rerun.
   always @(posedge CLK) begin
      if (wr)
         mem[addr] <= ac;
   end

`ifdef CPU_TRACE_EN
   always @(posedge CLK) begin
      if (RST && !halt && phase == PH_OP_ADDR)
         $display("[%0t] risc_cpu pc=%0d op=%0d operand=%0d ac=%02h",
                  $time, pc, opcode, ir[AWIDTH-1:0], ac);
   end
`endif

endmodule

// File: tb/tb_risc_cpu.sv
// Directed program tests for risc_cpu; a monitor checks pc/AC/memory/latency
// against queued expectations each time HALT rises.
module tb_risc_cpu;

   typedef struct packed {
      logic [4:0] pc;
      logic [7:0] ac;
      logic       chk_mem;
      logic [4:0] maddr;
      logic [7:0] mval;
      logic [7:0] cycles;
   } exp_t;

   logic CLK;
   logic RST;
   logic HALT;

   exp_t exp_q[$];
   int   checks;
   int   errors;
   int   edge_cnt;
   logic prev_halt;

   risc_cpu dut (
      .CLK  (CLK),
      .RST  (RST),
      .HALT (HALT)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK or negedge RST) begin
      if (!RST) edge_cnt <= 0;
      else      edge_cnt <= edge_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk_exp(input logic [4:0] pc, input logic [7:0] ac,
                                   input logic chk_mem, input logic [4:0] maddr,
                                   input logic [7:0] mval, input logic [7:0] cycles);
      exp_t e;
      e.pc = pc; e.ac = ac; e.chk_mem = chk_mem;
      e.maddr = maddr; e.mval = mval; e.cycles = cycles;
      return e;
   endfunction

   // monitor / scoreboard
   initial prev_halt = 1'b0;
   always @(negedge CLK) begin
      exp_t e;
      if (HALT === 1'b1 && prev_halt === 1'b0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_halt", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("halt_pc", 32'(dut.pc), 32'(e.pc));
            check("halt_ac", 32'(dut.ac), 32'(e.ac));
            check("halt_cycles", 32'(edge_cnt), 32'(e.cycles));
            if (e.chk_mem)
               check("halt_mem", 32'(dut.mem[e.maddr]), 32'(e.mval));
         end
      end
      prev_halt = HALT;
   end

   // driver tasks
   task automatic hold_reset_and_clear();
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      for (int i = 0; i < 32; i++) dut.mem[i] = 8'h00;
   endtask

   task automatic wait_halt();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         if (HALT) begin
            ok = 1'b1;
            break;
         end
      end
      check("halt_timeout", 32'(ok), 32'd1);
   endtask

   task automatic run_prog(input exp_t e);
      exp_q.push_back(e);
      @(negedge CLK);
      RST = 1'b1;
      wait_halt();
      @(negedge CLK);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic load_add_sto();
      hold_reset_and_clear();
      dut.mem[0]  = 8'hAA;   // LDA 10
      dut.mem[1]  = 8'h4B;   // ADD 11
      dut.mem[2]  = 8'hCC;   // STO 12
      dut.mem[3]  = 8'h00;   // HLT
      dut.mem[10] = 8'hF0;
      dut.mem[11] = 8'h25;
      dut.mem[12] = 8'h77;
   endtask

   task automatic load_skz(input logic [7:0] v10);
      hold_reset_and_clear();
      dut.mem[0]  = 8'hAA;   // LDA 10
      dut.mem[1]  = 8'h20;   // SKZ
      dut.mem[2]  = 8'h00;   // HLT
      dut.mem[3]  = 8'h8B;   // XOR 11
      dut.mem[4]  = 8'h00;   // HLT
      dut.mem[10] = v10;
      dut.mem[11] = 8'h5A;
   endtask

   initial begin
      logic ok;
      checks = 0;
      errors = 0;
      RST    = 1'b0;
      repeat (2) @(negedge CLK);

      // reset state
      check("rst_pc", 32'(dut.pc), 32'd0);
      check("rst_ac", 32'(dut.ac), 32'd0);
      check("rst_ir", 32'(dut.ir), 32'd0);
      check("rst_phase", 32'(dut.phase), 32'd0);
      check("rst_halt", 32'(HALT), 32'd0);

      // HLT at address 0
      hold_reset_and_clear();
      run_prog(mk_exp(5'd1, 8'h00, 1'b0, 5'd0, 8'h00, 8'd5));

      // LDA/ADD wrap/STO
      load_add_sto();
      run_prog(mk_exp(5'd4, 8'h15, 1'b1, 5'd12, 8'h15, 8'd29));

      // frozen after halt
      repeat (20) @(negedge CLK);
      check("frozen_halt", 32'(HALT), 32'd1);
      check("frozen_pc", 32'(dut.pc), 32'd4);
      check("frozen_ac", 32'(dut.ac), 32'h15);
      check("frozen_mem12", 32'(dut.mem[12]), 32'h15);
      check("frozen_mem11", 32'(dut.mem[11]), 32'h25);
      check("frozen_phase", 32'(dut.phase), 32'd5);

      // SKZ taken and not taken
      load_skz(8'h00);
      run_prog(mk_exp(5'd5, 8'h5A, 1'b0, 5'd0, 8'h00, 8'd29));
      load_skz(8'h01);
      run_prog(mk_exp(5'd3, 8'h01, 1'b0, 5'd0, 8'h00, 8'd21));

      // JMP over a field of HLTs
      hold_reset_and_clear();
      dut.mem[0] = 8'hF7;   // JMP 23
      run_prog(mk_exp(5'h18, 8'h00, 1'b0, 5'd0, 8'h00, 8'd13));

      // SKZ at address 31 wraps to 1
      hold_reset_and_clear();
      dut.mem[0]  = 8'hFF;  // JMP 31
      dut.mem[31] = 8'h20;  // SKZ
      dut.mem[0]  = 8'hFF;
      dut.mem[1]  = 8'h00;  // HLT
      run_prog(mk_exp(5'd2, 8'h00, 1'b0, 5'd0, 8'h00, 8'd21));

      // AND
      hold_reset_and_clear();
      dut.mem[0]  = 8'hAA;  // LDA 10
      dut.mem[1]  = 8'h6B;  // AND 11
      dut.mem[2]  = 8'h00;  // HLT
      dut.mem[10] = 8'h3C;
      dut.mem[11] = 8'h0F;
      run_prog(mk_exp(5'd3, 8'h0C, 1'b0, 5'd0, 8'h00, 8'd21));

      // reset during ALU_OP of STO, then rerun
      load_add_sto();
      @(negedge CLK);
      RST = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (dut.phase == 3'd6 && dut.ir[7:5] == 3'd6) begin
            ok = 1'b1;
            break;
         end
      end
      check("sto_phase_found", 32'(ok), 32'd1);
      RST = 1'b0;
      #1;
      check("midrst_mem12", 32'(dut.mem[12]), 32'h77);
      check("midrst_pc", 32'(dut.pc), 32'd0);
      check("midrst_ac", 32'(dut.ac), 32'd0);
      check("midrst_halt", 32'(HALT), 32'd0);
      @(negedge CLK);
      check("midrst_mem12_hold", 32'(dut.mem[12]), 32'h77);
      run_prog(mk_exp(5'd4, 8'h15, 1'b1, 5'd12, 8'h15, 8'd29));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
